// File: rtl/unstriping_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// unstriping_pkg : shared types and constants for the lane re-merge block
// Revision 1.0
// ---------------------------------------------------------------------------
package unstriping_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_sel_t;

    localparam logic [DATA_W_DEF-1:0] DATA_OUT_RST = '0;

endpackage
`default_nettype wire

// File: rtl/unstriping_lane_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lane_fifo : synchronous per-lane FIFO, simultaneous push/pop legal when full
// Revision 1.0
// ---------------------------------------------------------------------------
module lane_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q;
    logic [AW-1:0]     rptr_q;
    logic [CW-1:0]     count_q;
    logic              w_do_push;
    logic              w_do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A pop frees the slot a same-cycle push needs, so full only blocks an unpopped push
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (w_do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (w_do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/unstriping.sv
`default_nettype none
// ---------------------------------------------------------------------------
// unstriping : merges two striped lanes back into one in-order word stream
// Revision 1.0
// ---------------------------------------------------------------------------
module unstriping
    import unstriping_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] lane_0,
    input  logic              valid_0,
    input  logic [DATA_W-1:0] lane_1,
    input  logic              valid_1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              overflow_0,
    output logic              overflow_1
);

    localparam int CW = $clog2(DEPTH) + 1;

    lane_sel_t         sel_q, sel_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;
    logic              overflow_0_q, overflow_0_d;
    logic              overflow_1_q, overflow_1_d;

    logic [DATA_W-1:0] w_rdata_0, w_rdata_1;
    logic              w_full_0, w_full_1;
    logic              w_empty_0, w_empty_1;
    logic [CW-1:0]     w_cnt_0, w_cnt_1;
    logic              w_push_0, w_push_1;
    logic              w_pop_0, w_pop_1;

    lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_0 (
        .clk_i   (clk_2f),
        .rst_i   (reset),
        .push_i  (w_push_0),
        .pop_i   (w_pop_0),
        .wdata_i (lane_0),
        .rdata_o (w_rdata_0),
        .full_o  (w_full_0),
        .empty_o (w_empty_0),
        .count_o (w_cnt_0)
    );

    lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
        .clk_i   (clk_2f),
        .rst_i   (reset),
        .push_i  (w_push_1),
        .pop_i   (w_pop_1),
        .wdata_i (lane_1),
        .rdata_o (w_rdata_1),
        .full_o  (w_full_1),
        .empty_o (w_empty_1),
        .count_o (w_cnt_1)
    );

    always_comb begin
        // Only the in-order lane may pop; the other lane waits even if it has data
        w_pop_0      = (sel_q == LANE0) && !w_empty_0;
        w_pop_1      = (sel_q == LANE1) && !w_empty_1;
        w_push_0     = valid_0 && (!w_full_0 || w_pop_0);
        w_push_1     = valid_1 && (!w_full_1 || w_pop_1);
        sel_d        = sel_q;
        data_out_d   = DATA_W'(DATA_OUT_RST);
        valid_out_d  = 1'b0;
        overflow_0_d = overflow_0_q || (valid_0 && !w_pop_0 && (w_cnt_0 == CW'(DEPTH)));
        overflow_1_d = overflow_1_q || (valid_1 && !w_pop_1 && (w_cnt_1 == CW'(DEPTH)));
        if (w_pop_0) begin
            data_out_d  = w_rdata_0;
            valid_out_d = 1'b1;
            sel_d       = LANE1;
        end else if (w_pop_1) begin
            data_out_d  = w_rdata_1;
            valid_out_d = 1'b1;
            sel_d       = LANE0;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            sel_q        <= LANE0;
            data_out_q   <= DATA_W'(DATA_OUT_RST);
            valid_out_q  <= 1'b0;
            overflow_0_q <= 1'b0;
            overflow_1_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            overflow_0_q <= overflow_0_d;
            overflow_1_q <= overflow_1_d;
        end
    end

    assign data_out   = data_out_q;
    assign valid_out  = valid_out_q;
    assign overflow_0 = overflow_0_q;
    assign overflow_1 = overflow_1_q;

endmodule
`default_nettype wire

// File: tb/tb_unstriping.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_unstriping : directed stimulus with a queued scoreboard for unstriping
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_unstriping;

    logic        clk_2f;
    logic        reset;
    logic [31:0] lane_0;
    logic        valid_0;
    logic [31:0] lane_1;
    logic        valid_1;
    logic [31:0] data_out;
    logic        valid_out;
    logic        overflow_0;
    logic        overflow_1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    unstriping dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .lane_0     (lane_0),
        .valid_0    (valid_0),
        .lane_1     (lane_1),
        .valid_1    (valid_1),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .overflow_0 (overflow_0),
        .overflow_1 (overflow_1)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    always @(posedge clk_2f) cyc <= cyc + 1;

    // Monitor: every emitted word is matched against the head of the queue
    always @(negedge clk_2f) begin
        if (reset === 1'b0 && valid_out === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out actual=%h required=no_output cyc=%0d", data_out, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (data_out !== mon_e.data) begin
                    failures++;
                    $display("FAIL out_data actual=%h required=%h cyc=%0d", data_out, mon_e.data, cyc);
                end
                if (mon_e.cyc >= 0) begin
                    checks++;
                    if (cyc != mon_e.cyc) begin
                        failures++;
                        $display("FAIL out_cycle data=%h actual=%0d required=%0d", mon_e.data, cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic drv(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
        valid_0 = v0;
        lane_0  = d0;
        valid_1 = v1;
        lane_1  = d1;
        @(posedge clk_2f);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drv(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic wait_drain(input string nm, input int limit);
        int waited;
        waited = 0;
        while (exp_q.size() > 0 && waited < limit) begin
            idle(1);
            waited++;
        end
        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain actual=%0d_pending required=0_pending", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        valid_0 = 1'b1;
        lane_0  = 32'hDEAD_0000;
        valid_1 = 1'b1;
        lane_1  = 32'hDEAD_0001;

        // Reset held 3 cycles while both lanes present words
        repeat (3) begin
            @(posedge clk_2f);
            #1;
        end
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_valid_out", {31'h0, valid_out}, 32'h0);
        chk("rst_overflow_0", {31'h0, overflow_0}, 32'h0);
        chk("rst_overflow_1", {31'h0, overflow_1}, 32'h0);
        reset = 1'b0;
        idle(1);
        chk("post_rst_idle_valid", {31'h0, valid_out}, 32'h0);
        idle(3);

        // Aligned striper pattern
        n = cyc;
        expect_word(32'hA0, n + 2);
        expect_word(32'hB1, n + 3);
        expect_word(32'hA2, n + 4);
        expect_word(32'hB3, n + 5);
        drv(1'b1, 32'hA0, 1'b0, 32'h0);
        drv(1'b0, 32'h0,  1'b1, 32'hB1);
        drv(1'b1, 32'hA2, 1'b0, 32'h0);
        drv(1'b0, 32'h0,  1'b1, 32'hB3);
        wait_drain("aligned", 20);

        // Lane 1 lags lane 0 by three cycles
        n = cyc;
        expect_word(32'hA0, n + 2);
        expect_word(32'hB1, n + 5);
        expect_word(32'hA2, n + 6);
        expect_word(32'hB3, n + 7);
        drv(1'b1, 32'hA0, 1'b0, 32'h0);
        drv(1'b1, 32'hA2, 1'b0, 32'h0);
        drv(1'b0, 32'h0,  1'b0, 32'h0);
        drv(1'b0, 32'h0,  1'b1, 32'hB1);
        drv(1'b0, 32'h0,  1'b1, 32'hB3);
        wait_drain("skew", 20);

        // Overflow: 0x10 pops immediately, 0x11..0x14 fill lane 0, 0x15 is dropped
        n = cyc;
        expect_word(32'h10, n + 2);
        for (int i = 0; i < 6; i++) drv(1'b1, 32'h10 + i, 1'b0, 32'h0);
        chk("ovf_set_overflow_0", {31'h0, overflow_0}, 32'h1);
        chk("ovf_overflow_1", {31'h0, overflow_1}, 32'h0);
        chk("ovf_fifo0_count", {29'h0, dut.u_fifo_0.count_o}, 32'h4);
        idle(3);
        chk("ovf_sticky_overflow_0", {31'h0, overflow_0}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            expect_word(32'hB0 + i, -1);
            expect_word(32'h11 + i, -1);
        end
        expect_word(32'hB4, -1);
        for (int i = 0; i < 5; i++) drv(1'b0, 32'h0, 1'b1, 32'hB0 + i);
        wait_drain("ovf", 30);
        chk("ovf_end_overflow_0", {31'h0, overflow_0}, 32'h1);
        chk("ovf_end_overflow_1", {31'h0, overflow_1}, 32'h0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("ovf_cleared_by_rst", {31'h0, overflow_0}, 32'h0);

        // Full lane 0 pushes exactly on its pop edges
        for (int i = 0; i < 7; i++) begin
            expect_word(32'hC0 + i, -1);
            expect_word(32'hD0 + i, -1);
        end
        for (int i = 0; i < 5; i++) drv(1'b1, 32'hC0 + i, 1'b0, 32'h0);
        chk("full_fill_count", {29'h0, dut.u_fifo_0.count_o}, 32'h4);
        drv(1'b0, 32'h0,  1'b1, 32'hD0);
        idle(1);
        drv(1'b1, 32'hC5, 1'b1, 32'hD1);
        chk("full_pushpop_count_a", {29'h0, dut.u_fifo_0.count_o}, 32'h4);
        chk("full_pushpop_ovf_a", {31'h0, overflow_0}, 32'h0);
        idle(1);
        drv(1'b1, 32'hC6, 1'b1, 32'hD2);
        chk("full_pushpop_count_b", {29'h0, dut.u_fifo_0.count_o}, 32'h4);
        for (int i = 3; i < 7; i++) drv(1'b0, 32'h0, 1'b1, 32'hD0 + i);
        wait_drain("full", 30);
        chk("full_end_ovf_0", {31'h0, overflow_0}, 32'h0);
        chk("full_end_ovf_1", {31'h0, overflow_1}, 32'h0);

        // Mid-stream reset discards three buffered lane 1 words
        for (int i = 1; i < 4; i++) drv(1'b0, 32'h0, 1'b1, 32'hE0 + i);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("midrst_valid_out", {31'h0, valid_out}, 32'h0);
        n = cyc;
        expect_word(32'hF0, n + 2);
        expect_word(32'hF1, n + 3);
        drv(1'b1, 32'hF0, 1'b0, 32'h0);
        drv(1'b0, 32'h0,  1'b1, 32'hF1);
        wait_drain("midrst", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
